// File: rtl/i2c_pkg.sv
// Shared types for the I2C init sequencer: table entry layout, FSM encoding and the
// default power-up register table walked by the sequencer.
package i2c_pkg;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] sub;
        logic [7:0] data;
    } entry_t;

    localparam int ENTRY_W   = 23;
    localparam int TABLE_LEN = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACC  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_ADVANCE   = 3'd4
    } state_t;

    // Entries past TABLE_LEN read back as all-zero writes.
    localparam entry_t INIT_TABLE [TABLE_LEN] = '{
        '{addr: 7'h55, sub: 8'hAA, data: 8'hAA},
        '{addr: 7'h68, sub: 8'h20, data: 8'h0F},
        '{addr: 7'h68, sub: 8'h21, data: 8'h00},
        '{addr: 7'h68, sub: 8'h22, data: 8'h3C},
        '{addr: 7'h1A, sub: 8'h00, data: 8'h80},
        '{addr: 7'h1A, sub: 8'h01, data: 8'h17},
        '{addr: 7'h1A, sub: 8'h04, data: 8'h12},
        '{addr: 7'h1A, sub: 8'h09, data: 8'h01}
    };

endpackage

// File: rtl/i2c_seq_rom.sv
// Combinational lookup of one init-table entry by index; the sequencer registers the result.
import i2c_pkg::*;

module i2c_seq_rom (
    input  logic [7:0]         idx_i,
    output logic [ENTRY_W-1:0] entry_o
);

    always_comb begin
        entry_o = '0;
        if (idx_i < 8'(TABLE_LEN)) begin
            entry_o = INIT_TABLE[idx_i[2:0]];
        end
    end

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks the init table, handing one write at a time to an I2C master via start/ready/done.
// Optional per-transfer watchdog when I2C_SEQ_TIMEOUT_EN is defined.
import i2c_pkg::*;

module i2c_init_sequencer #(
    parameter int N_ENTRIES = 8,
    parameter int TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       ready,
    input  logic       done,
    output logic       start,
    output logic [6:0] addr,
    output logic [7:0] sub,
    output logic [7:0] data,
    output logic       busy,
    output logic       seq_done,
    output logic [7:0] index,
    output logic       error,
    output logic [2:0] state_dbg
);

    // Handshake: start rises in ISSUE and stays high until the master has shown ready=1
    // (accepted) and then ready=0 (running); done is only honoured in WAIT_DONE and must
    // fall again before the next entry is issued.
    localparam logic [7:0] LAST_IDX = 8'(N_ENTRIES - 1);

    state_t             state_q;
    entry_t             entry_q;
    logic [7:0]         index_q;
    logic               start_q;
    logic               seq_done_q;
    logic [7:0]         rom_idx;
    logic [ENTRY_W-1:0] entry_d;

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] cnt_q;
    logic        error_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    // The ROM is addressed with the index about to be loaded, so the entry registers
    // update on the same edge as index.
    assign rom_idx = (state_q == ST_ADVANCE) ? index_q + 8'd1 : 8'd0;

    i2c_seq_rom u_rom (
        .idx_i   (rom_idx),
        .entry_o (entry_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            entry_q    <= '0;
            index_q    <= '0;
            start_q    <= 1'b0;
            seq_done_q <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
            cnt_q      <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            seq_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        state_q <= ST_ISSUE;
                        index_q <= '0;
                        entry_q <= entry_t'(entry_d);
                        start_q <= 1'b1;
`ifdef I2C_SEQ_TIMEOUT_EN
                        cnt_q   <= '0;
                        error_q <= 1'b0;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (ready) state_q <= ST_WAIT_ACC;
                end
                ST_WAIT_ACC: begin
                    if (!ready) begin
                        start_q <= 1'b0;
                        state_q <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (done) state_q <= ST_ADVANCE;
                end
                ST_ADVANCE: begin
                    if (!done) begin
                        if (index_q == LAST_IDX) begin
                            state_q    <= ST_IDLE;
                            seq_done_q <= 1'b1;
                        end else begin
                            state_q <= ST_ISSUE;
                            index_q <= index_q + 8'd1;
                            entry_q <= entry_t'(entry_d);
                            start_q <= 1'b1;
`ifdef I2C_SEQ_TIMEOUT_EN
                            cnt_q   <= '0;
`endif
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    start_q <= 1'b0;
                end
            endcase
`ifdef I2C_SEQ_TIMEOUT_EN
            // Abort overrides whatever the handshake decided this cycle.
            if (state_q == ST_ISSUE || state_q == ST_WAIT_ACC || state_q == ST_WAIT_DONE) begin
                if (cnt_q == TO_LAST) begin
                    state_q    <= ST_IDLE;
                    start_q    <= 1'b0;
                    error_q    <= 1'b1;
                    seq_done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
`endif
        end
    end

    assign start     = start_q;
    assign addr      = entry_q.addr;
    assign sub       = entry_q.sub;
    assign data      = entry_q.data;
    assign busy      = (state_q != ST_IDLE);
    assign seq_done  = seq_done_q;
    assign index     = index_q;
    assign state_dbg = state_q;
`ifdef I2C_SEQ_TIMEOUT_EN
    assign error     = error_q;
`else
    assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_init_sequencer.sv
// Bench for i2c_init_sequencer: randomized master model on a 2-entry instance plus a
// directed 1-entry instance; expected transfers come from the bench's own copy of the table.
module tb_i2c_init_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int LONG_DLY = 40;
  localparam int GO_HOLD  = 80;
`else
  localparam int LONG_DLY = 60;
  localparam int GO_HOLD  = 100;
`endif

  logic reset = 1'b0;
  logic go_a = 1'b0, ready_a = 1'b1, done_a = 1'b0;
  logic go_b = 1'b0, ready_b = 1'b1, done_b = 1'b0;
  logic start_a, busy_a, seq_done_a, error_a;
  logic start_b, busy_b, seq_done_b, error_b;
  logic [6:0] addr_a, addr_b;
  logic [7:0] sub_a, data_a, index_a, sub_b, data_b, index_b;
  logic [2:0] state_a, state_b;

  i2c_init_sequencer #(.N_ENTRIES(2), .TIMEOUT(50)) dut_a (
    .clk(clk), .reset(reset), .go(go_a), .ready(ready_a), .done(done_a),
    .start(start_a), .addr(addr_a), .sub(sub_a), .data(data_a), .busy(busy_a),
    .seq_done(seq_done_a), .index(index_a), .error(error_a), .state_dbg(state_a)
  );

  i2c_init_sequencer #(.N_ENTRIES(1), .TIMEOUT(50)) dut_b (
    .clk(clk), .reset(reset), .go(go_b), .ready(ready_b), .done(done_b),
    .start(start_b), .addr(addr_b), .sub(sub_b), .data(data_b), .busy(busy_b),
    .seq_done(seq_done_b), .index(index_b), .error(error_b), .state_dbg(state_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0, n_pass = 0, n_fail = 0;
  logic [22:0] ref_tbl [2] = '{{7'h55, 8'hAA, 8'hAA}, {7'h68, 8'h20, 8'h0F}};
  logic [30:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_run();
    for (int i = 0; i < 2; i++) begin
      logic [7:0] ii;
      ii = 8'(i);
      exp_q.push_back({ii, ref_tbl[i]});
    end
  endtask

  // ---------------- master model for dut_a ----------------
  logic stuck = 1'b0, no_done = 1'b0, long_dly = 1'b0;
  int m_ph = 0, m_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      m_ph = 0; ready_a = 1'b1; done_a = 1'b0;
    end else begin
      case (m_ph)
        0: begin
          ready_a = !stuck; done_a = 1'b0;
          if (start_a && !stuck) begin m_cnt = int'($urandom_range(1, 3)); m_ph = 1; end
        end
        1: if (m_cnt <= 1) begin
             ready_a = 1'b0;
             m_cnt = long_dly ? LONG_DLY : int'($urandom_range(5, 25));
             m_ph = 2;
           end else m_cnt--;
        2: if (!busy_a) begin ready_a = 1'b1; m_ph = 0; end
           else if (m_cnt <= 1) begin
             if (!no_done) begin done_a = 1'b1; m_cnt = int'($urandom_range(1, 3)); m_ph = 3; end
           end else m_cnt--;
        3: if (m_cnt <= 1) begin done_a = 1'b0; ready_a = 1'b1; m_ph = 0; end
           else m_cnt--;
        default: m_ph = 0;
      endcase
    end
  end

  // ---------------- monitors ----------------
  int cyc = 0, seq_cnt_a = 0, zero_run = 0, t_start = 0, t_done = 0;
  logic prev_start_a = 1'b0, prev_sd_a = 1'b0;
  int b_starts = 0, b_seq = 0;
  logic prev_start_b = 1'b0;
  logic [30:0] b_got = '0;

  always @(negedge clk) begin
    logic [30:0] got, exp;
    cyc++;
    if (!reset) begin
      prev_start_a = 1'b0; prev_sd_a = 1'b0; zero_run = 0;
    end else begin
      if (start_a && !prev_start_a) begin
        t_start = cyc;
        if (index_a != 8'd0) check("start_gap", (zero_run >= 2), 1);
        got = {index_a, addr_a, sub_a, data_a};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check("start_entry", got, exp);
      end
      if (start_a) zero_run = 0; else zero_run++;
      if (prev_sd_a) check("seq_done_width", seq_done_a, 0);
      if (seq_done_a) begin seq_cnt_a++; t_done = cyc; end
      prev_start_a = start_a;
      prev_sd_a = seq_done_a;
    end
  end

  always @(negedge clk) begin
    if (!reset) prev_start_b = 1'b0;
    else begin
      if (start_b && !prev_start_b) begin
        b_starts++;
        b_got = {index_b, addr_b, sub_b, data_b};
      end
      if (seq_done_b) b_seq++;
      prev_start_b = start_b;
    end
  end

  task automatic wait_seq(input string tag, input int s0, input int budget);
    int n = 0;
    while (seq_cnt_a == s0 && n < budget) begin @(negedge clk); n++; end
    check(tag, (seq_cnt_a != s0), 1);
  endtask

  task automatic pulse_go_a();
    go_a = 1'b1; @(negedge clk); go_a = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s, n, r;
    repeat (3) @(negedge clk);
    check("rst_start", start_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_seq_done", seq_done_a, 0);
    check("rst_index", index_a, 0);
    check("rst_error", error_a, 0);
    check("rst_entry", {addr_a, sub_a, data_a}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // randomized runs with stray go pokes while busy
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(1, 10)) @(negedge clk);
      s = seq_cnt_a;
      push_run();
      pulse_go_a();
      check("busy_after_go", busy_a, 1);
      r = int'($urandom_range(3, 40));
      repeat (r) @(negedge clk);
      if (busy_a) pulse_go_a();
      wait_seq("run_seq_done", s, 400);
      check("run_idle_busy", busy_a, 0);
      check("run_queue_empty", exp_q.size(), 0);
      check("run_error", error_a, 0);
    end

    // go held high through most of one run
    repeat (5) @(negedge clk);
    long_dly = 1'b1;
    s = seq_cnt_a;
    push_run();
    pulse_go_a();
    n = 0;
    while (!start_a && n < 20) begin @(negedge clk); n++; end
    check("hold_first_start", start_a, 1);
    go_a = 1'b1;
    repeat (GO_HOLD) @(negedge clk);
    go_a = 1'b0;
    wait_seq("hold_seq_done", s, 400);
    repeat (10) @(negedge clk);
    check("hold_one_sequence", seq_cnt_a - s, 1);
    check("hold_queue_empty", exp_q.size(), 0);
    check("hold_busy", busy_a, 0);
    long_dly = 1'b0;

    // asynchronous reset while entry 1 waits for done
    push_run();
    pulse_go_a();
    n = 0;
    while (!(index_a == 8'd1 && !start_a && busy_a) && n < 300) begin @(negedge clk); n++; end
    check("reach_wait_done_1", (index_a == 8'd1 && !start_a && busy_a), 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_start", start_a, 0);
    check("mid_rst_index", index_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_entry", {addr_a, sub_a, data_a}, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", busy_a, 0);
    s = seq_cnt_a;
    push_run();
    pulse_go_a();
    wait_seq("post_rst_seq_done", s, 400);
    check("post_rst_queue_empty", exp_q.size(), 0);

`ifdef I2C_SEQ_TIMEOUT_EN
    // master never raises done: watchdog aborts after 50 cycles
    repeat (5) @(negedge clk);
    no_done = 1'b1;
    s = seq_cnt_a;
    push_run();
    pulse_go_a();
    wait_seq("to_seq_done", s, 200);
    @(negedge clk);
    check("to_cycles", t_done - t_start, 50);
    check("to_error", error_a, 1);
    check("to_busy", busy_a, 0);
    check("to_start", start_a, 0);
    exp_q.delete();
    no_done = 1'b0;
    repeat (5) @(negedge clk);
    check("to_error_sticky", error_a, 1);
    s = seq_cnt_a;
    push_run();
    pulse_go_a();
    check("to_error_cleared", error_a, 0);
    wait_seq("to_rerun_seq_done", s, 400);
    check("to_rerun_error", error_a, 0);
    check("to_rerun_queue_empty", exp_q.size(), 0);
`else
    // ready stuck low: start stays up, no progress until ready is released
    repeat (5) @(negedge clk);
    stuck = 1'b1;
    @(negedge clk);
    s = seq_cnt_a;
    push_run();
    pulse_go_a();
    repeat (60) @(negedge clk);
    check("stuck_start", start_a, 1);
    check("stuck_index", index_a, 0);
    check("stuck_busy", busy_a, 1);
    check("stuck_no_done", seq_cnt_a - s, 0);
    check("stuck_error", error_a, 0);
    stuck = 1'b0;
    wait_seq("stuck_release_seq_done", s, 400);
    check("stuck_queue_empty", exp_q.size(), 0);
`endif

    // single-entry instance with a stray done before go
    done_b = 1'b1;
    repeat (4) @(negedge clk);
    check("b_stray_done_idle", {busy_b, start_b, seq_done_b}, 0);
    go_b = 1'b1; @(negedge clk); go_b = 0;
    @(negedge clk);
    ready_b = 1'b0; done_b = 1'b0;
    n = 0;
    while (start_b && n < 20) begin @(negedge clk); n++; end
    check("b_start_dropped", start_b, 0);
    repeat (6) @(negedge clk);
    check("b_waiting", busy_b, 1);
    done_b = 1'b1;
    repeat (2) @(negedge clk);
    done_b = 1'b0; ready_b = 1'b1;
    n = 0;
    while (b_seq == 0 && n < 20) begin @(negedge clk); n++; end
    repeat (10) @(negedge clk);
    check("b_one_start", b_starts, 1);
    check("b_one_seq_done", b_seq, 1);
    check("b_entry", b_got, {8'd0, ref_tbl[0]});
    check("b_idle", busy_b, 0);
    check("b_error", error_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_init_sequencer.md
I2C_INIT_SEQUENCER -- requirements
Module: i2c_init_sequencer

Interface
REQ-001 Parameter N_ENTRIES, default 8: number of table entries, 1..256.
REQ-002 Parameter TIMEOUT, default 4096: cycles allowed per transfer before abort (timeout build only).
REQ-003 clk  input  1: single clock, rising edge; one clock domain only.
REQ-004 reset  input  1: asynchronous assert, active-low, synchronously deasserted upstream.
REQ-005 go  input  1: request to run the whole table; sampled only in IDLE.
REQ-006 ready  input  1: master idle/able to accept start.
REQ-007 done  input  1: master transfer complete; level, held at least 1 cycle.
REQ-008 start  output  1: transfer request to the master.
REQ-009 addr  output  7: 7-bit slave address of the current entry.
REQ-010 sub  output  8: sub-address (register) of the current entry.
REQ-011 data  output  8: write byte of the current entry.
REQ-012 busy  output  1: high in every state except IDLE.
REQ-013 seq_done  output  1: one-cycle pulse when the last entry completes.
REQ-014 index  output  8: current entry number, 0-based.
REQ-015 error  output  1: sticky timeout flag, cleared by the next accepted go (timeout build only, else tied 0).

Function
REQ-016 States SHALL be IDLE, ISSUE, WAIT_ACC, WAIT_DONE, ADVANCE.
REQ-017 IDLE -> ISSUE when go=1; index SHALL load 0 on the same edge.
REQ-018 addr/sub/data SHALL be registered from the table entry at index and stable from ISSUE entry until ADVANCE exit.
REQ-019 ISSUE: start=1; -> WAIT_ACC when ready=1 is sampled with start=1.
REQ-020 WAIT_ACC: start held 1 until ready=0 sampled, then start=0 on the following edge and -> WAIT_DONE.
REQ-021 WAIT_DONE: start=0; -> ADVANCE when done=1.
REQ-022 ADVANCE: done must return to 0 first; if index==N_ENTRIES-1 -> IDLE with seq_done pulsed 1 cycle; else index+1 and -> ISSUE.
REQ-023 Every entry SHALL take at least 4 cycles; consecutive start pulses SHALL be separated by at least 2 start=0 cycles.
REQ-024 go asserted while busy SHALL be ignored; no queuing.
REQ-025 done=1 observed in IDLE or ISSUE SHALL be ignored.
REQ-026 index SHALL never exceed N_ENTRIES-1; no wrap-around past the last entry.
REQ-027 N_ENTRIES=1: a single transfer, then seq_done.

Reset
REQ-028 Reset low SHALL immediately force IDLE, start=0, busy=0, seq_done=0, index=0, error=0, addr=0, sub=0, data=0.
REQ-029 Reset mid-transfer SHALL drop start at once; no resume; the next go restarts at entry 0.

Configuration
REQ-030 Macro I2C_SEQ_TIMEOUT_EN defined: a 16-bit counter clears on each ISSUE entry and counts in ISSUE, WAIT_ACC and WAIT_DONE; at TIMEOUT it forces start=0, sets error=1, pulses seq_done and -> IDLE.
REQ-031 Macro undefined: no counter logic; error tied 0; sequencer waits indefinitely.

Structure
REQ-032 Shared package i2c_pkg SHALL hold the entry typedef (addr 7, sub 8, data 8), the default init-table constant, and the state encoding.
REQ-033 Sub-module i2c_seq_rom SHALL map index to entry combinationally from the package table; the sequencer registers its output.

Verification
REQ-034 Behavioural master model: ready drops 2 cycles after start, done pulses 20 cycles later. Table {55,AA,AA},{68,20,0F}, N_ENTRIES=2, go pulse -> exactly two start pulses with those values, then seq_done 1 cycle, busy=0.
REQ-035 go held high for 100 cycles during a run -> only one sequence; index runs 0,1 once.
REQ-036 Reset low while in WAIT_DONE of entry 1 -> start=0 and index=0 within the same cycle; the next go issues entry 0.
REQ-037 Timeout build, TIMEOUT=50, master never raises done -> after 50 cycles start=0, error=1, seq_done pulse, IDLE; the next go clears error.
REQ-038 ready stuck 0 in the non-timeout build -> start held 1 indefinitely, no advance; releasing ready resumes normally.
REQ-039 N_ENTRIES=1 with done asserted in IDLE before go -> stray done ignored; exactly one transfer.
